pic_cmd_sequencer: RTL and testbench

// - Read/write control sequencer of the 8259A-style PIC. It decodes CPU bus strobes and steers the data bus buffer via rd_flag/wr_flag.
// - Walks the ICW1..ICW4 initialisation sequence, then latches OCW1/OCW2/OCW3.
// - Holds all configuration state and selects the byte returned on reads (IMR, IRR or ISR).

---
 rtl/pic_pkg.sv | 20 ++
 rtl/pic_strobe_edge.sv | 36 +++
 rtl/pic_cmd_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pic_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and bit positions for the PIC command sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } pic_state_e;

  // D4 distinguishes ICW1 from OCW2/OCW3 on a0=0 writes.
  localparam int unsigned ICW1_D4 = 4;
  // D3 distinguishes OCW3 (1) from OCW2 (0).
  localparam int unsigned OCW_D3  = 3;

  localparam logic RDSEL_IRR = 1'b0;
  localparam logic RDSEL_ISR = 1'b1;

endpackage

// File: rtl/pic_strobe_edge.sv
// Tracks the CPU write strobe, captures the written byte and flags the
// cycle in which the strobe ends (the commit cycle).
module pic_strobe_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_flag,
  input  logic       a0,
  input  logic [7:0] data_in,
  output logic       commit,
  output logic       cmd_a0,
  output logic [7:0] cmd_data
);

  logic wr_act_q;

  // Register the strobe and keep the last byte seen while it was active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_act_q <= 1'b0;
      cmd_a0   <= 1'b0;
      cmd_data <= '0;
    end else begin
      wr_act_q <= wr_flag;
      if (wr_flag) begin
        cmd_a0   <= a0;
        cmd_data <= data_in;
      end
    end
  end

  // Trailing edge of the strobe, or chip select dropped before wr_n.
  always_comb begin
    commit = wr_act_q & ~wr_flag;
  end

endmodule

// File: rtl/pic_cmd_sequencer.sv
// Read/write control sequencer of the 8259A-style PIC: bus strobe decode,
// ICW1..ICW4 initialisation walk, OCW latching and read-back selection.
module pic_cmd_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] IMR_RESET   = 8'h00,
  parameter logic       RDSEL_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] data_in,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  output logic       rd_flag,
  output logic       wr_flag,
  output logic [7:0] read_data,
  output logic       init_done,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic [7:0] cascade_cfg,
  output logic [4:0] icw4_mode,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       poll_req,
  output logic       icw1_pulse
);

  pic_state_e state_q, state_d;

  logic       commit;
  logic       c_a0;
  logic [7:0] c_data;
  logic       rdsel_q;

  logic ld_icw1, ld_icw2, ld_icw3, ld_icw4;
  logic ld_ocw1, ld_ocw2, ld_ocw3;

  // Strobe decode; simultaneous rd_n/wr_n yields neither flag.
  always_comb begin
    rd_flag = ~cs_n & ~rd_n & wr_n;
    wr_flag = ~cs_n & ~wr_n & rd_n;
  end

  pic_strobe_edge u_strobe (
    .clk      (clk),
    .reset    (reset),
    .wr_flag  (wr_flag),
    .a0       (a0),
    .data_in  (data_in),
    .commit   (commit),
    .cmd_a0   (c_a0),
    .cmd_data (c_data)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and command classification of the committed write.
  always_comb begin
    state_d = state_q;
    ld_icw1 = 1'b0;
    ld_icw2 = 1'b0;
    ld_icw3 = 1'b0;
    ld_icw4 = 1'b0;
    ld_ocw1 = 1'b0;
    ld_ocw2 = 1'b0;
    ld_ocw3 = 1'b0;
    if (commit) begin
      if (!c_a0 && c_data[ICW1_D4]) begin
        ld_icw1 = 1'b1;
        state_d = ST_WAIT_ICW2;
      end else begin
        case (state_q)
          ST_WAIT_ICW2: begin
            if (c_a0) begin
              ld_icw2 = 1'b1;
              if (!sngl)     state_d = ST_WAIT_ICW3;
              else if (ic4)  state_d = ST_WAIT_ICW4;
              else           state_d = ST_READY;
            end
          end
          ST_WAIT_ICW3: begin
            if (c_a0) begin
              ld_icw3 = 1'b1;
              state_d = ic4 ? ST_WAIT_ICW4 : ST_READY;
            end
          end
          ST_WAIT_ICW4: begin
            if (c_a0) begin
              ld_icw4 = 1'b1;
              state_d = ST_READY;
            end
          end
          ST_READY: begin
            if (c_a0)                 ld_ocw1 = 1'b1;
            else if (!c_data[OCW_D3]) ld_ocw2 = 1'b1;
            else                      ld_ocw3 = 1'b1;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Configuration registers loaded from committed ICW/OCW bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ltim        <= 1'b0;
      sngl        <= 1'b0;
      ic4         <= 1'b0;
      vector_base <= '0;
      cascade_cfg <= '0;
      icw4_mode   <= '0;
      imr         <= IMR_RESET;
      rdsel_q     <= RDSEL_RESET;
      ocw2_cmd    <= '0;
      ocw2_level  <= '0;
    end else begin
      if (ld_icw1) begin
        ltim      <= c_data[3];
        sngl      <= c_data[1];
        ic4       <= c_data[0];
        imr       <= IMR_RESET;
        rdsel_q   <= RDSEL_RESET;
        icw4_mode <= '0;
      end
      if (ld_icw2) vector_base <= c_data[7:3];
      if (ld_icw3) cascade_cfg <= c_data;
      if (ld_icw4) icw4_mode   <= c_data[4:0];
      if (ld_ocw1) imr         <= c_data;
      if (ld_ocw2) begin
        ocw2_cmd   <= c_data[7:5];
        ocw2_level <= c_data[2:0];
      end
      if (ld_ocw3 && c_data[1]) rdsel_q <= c_data[0];
    end
  end

  // One-cycle pulses in the cycle following the commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icw1_pulse <= 1'b0;
      ocw2_valid <= 1'b0;
      poll_req   <= 1'b0;
    end else begin
      icw1_pulse <= ld_icw1;
      ocw2_valid <= ld_ocw2;
      poll_req   <= ld_ocw3 & c_data[2];
    end
  end

  // Registered read-back byte; nothing is exposed before initialisation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
    end else if (state_q != ST_READY) begin
      read_data <= '0;
    end else if (a0) begin
      read_data <= imr;
    end else begin
      read_data <= (rdsel_q == RDSEL_ISR) ? isr : irr;
    end
  end

  // Initialisation complete indicator.
  always_comb begin
    init_done = (state_q == ST_READY);
  end

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Self-checking bench for pic_cmd_sequencer: directed vector table, corner
// sequences and randomized writes/reads against a queue-based model.
module tb_pic_cmd_sequencer;

  localparam logic [7:0] IMR_RST = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
  logic [7:0] data_in = '0, irr = '0, isr = '0;
  logic       rd_flag, wr_flag, init_done, ltim, sngl, ic4;
  logic       ocw2_valid, poll_req, icw1_pulse;
  logic [7:0] read_data, cascade_cfg, imr;
  logic [4:0] vector_base, icw4_mode;
  logic [2:0] ocw2_cmd, ocw2_level;

  int total = 0;
  int bad   = 0;

  pic_cmd_sequencer #(.IMR_RESET(IMR_RST), .RDSEL_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .a0(a0), .data_in(data_in), .irr(irr), .isr(isr),
    .rd_flag(rd_flag), .wr_flag(wr_flag), .read_data(read_data),
    .init_done(init_done), .vector_base(vector_base), .ltim(ltim),
    .sngl(sngl), .ic4(ic4), .cascade_cfg(cascade_cfg),
    .icw4_mode(icw4_mode), .imr(imr), .ocw2_valid(ocw2_valid),
    .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level), .poll_req(poll_req),
    .icw1_pulse(icw1_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Initialisation is modelled as a queue of ICW numbers still owed.
  bit         m_started;
  int         m_q[$];
  logic [4:0] m_vb;
  logic [2:0] m_lsi;
  logic [7:0] m_casc, m_imr;
  logic [4:0] m_i4;
  logic       m_rdsel;
  logic [2:0] m_cmd, m_lvl;
  logic       m_p_icw1, m_p_ocw2, m_p_poll;

  function automatic bit m_ready();
    return m_started && (m_q.size() == 0);
  endfunction

  task automatic model_reset();
    m_started = 0; m_q.delete();
    m_vb = '0; m_lsi = '0; m_casc = '0; m_imr = IMR_RST; m_i4 = '0;
    m_rdsel = 1'b0; m_cmd = '0; m_lvl = '0;
    m_p_icw1 = 0; m_p_ocw2 = 0; m_p_poll = 0;
  endtask

  task automatic model_write(input logic a, input logic [7:0] d);
    int h;
    m_p_icw1 = 0; m_p_ocw2 = 0; m_p_poll = 0;
    if (!a && d[4]) begin
      m_started = 1;
      m_lsi = {d[3], d[1], d[0]};
      m_imr = IMR_RST; m_rdsel = 1'b0; m_i4 = '0;
      m_q.delete();
      m_q.push_back(2);
      if (!d[1]) m_q.push_back(3);
      if (d[0])  m_q.push_back(4);
      m_p_icw1 = 1;
    end else if (!m_started) begin
      // writes before ICW1 have no effect
    end else if (m_q.size() > 0) begin
      if (a) begin
        h = m_q.pop_front();
        if (h == 2)      m_vb = d[7:3];
        else if (h == 3) m_casc = d;
        else             m_i4 = d[4:0];
      end
    end else if (a) begin
      m_imr = d;
    end else if (!d[3]) begin
      m_cmd = d[7:5]; m_lvl = d[2:0]; m_p_ocw2 = 1;
    end else begin
      if (d[1]) m_rdsel = d[0];
      if (d[2]) m_p_poll = 1;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  logic s_icw1, s_ocw2, s_poll;

  // Full write cycle; pulses are sampled in the cycle after the commit.
  task automatic do_write(input logic a, input logic [7:0] d);
    @(negedge clk); cs_n = 0; wr_n = 0; a0 = a; data_in = d;
    @(negedge clk);
    @(negedge clk); cs_n = 1; wr_n = 1;
    @(negedge clk);
    s_icw1 = icw1_pulse; s_ocw2 = ocw2_valid; s_poll = poll_req;
  endtask

  task automatic chk_pulses_clear(input string tag);
    @(negedge clk);
    chk({tag, " pulses_low"}, {icw1_pulse, ocw2_valid, poll_req}, 3'b000);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " init_done"}, init_done, m_ready());
    chk({tag, " vector_base"}, vector_base, m_vb);
    chk({tag, " ltim_sngl_ic4"}, {ltim, sngl, ic4}, m_lsi);
    chk({tag, " cascade_cfg"}, cascade_cfg, m_casc);
    chk({tag, " icw4_mode"}, icw4_mode, m_i4);
    chk({tag, " imr"}, imr, m_imr);
    chk({tag, " ocw2_cmd_level"}, {ocw2_cmd, ocw2_level}, {m_cmd, m_lvl});
  endtask

  task automatic wr_chk(input string tag, input logic a, input logic [7:0] d);
    model_write(a, d);
    do_write(a, d);
    chk({tag, " pulses"}, {s_icw1, s_ocw2, s_poll}, {m_p_icw1, m_p_ocw2, m_p_poll});
    chk_model(tag);
    chk_pulses_clear(tag);
  endtask

  task automatic rd_chk(input string tag, input logic a);
    logic [7:0] exp;
    @(negedge clk); cs_n = 0; rd_n = 0; a0 = a;
    @(negedge clk);
    if (!m_ready())  exp = 8'h00;
    else if (a)      exp = m_imr;
    else             exp = m_rdsel ? isr : irr;
    chk({tag, " rd_flag"}, {rd_flag, wr_flag}, 2'b10);
    chk({tag, " read_data"}, read_data, exp);
    cs_n = 1; rd_n = 1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic a; logic [7:0] d;
    logic done; logic [4:0] vb; logic [2:0] lsi; logic [7:0] casc;
    logic [4:0] i4; logic [7:0] imr; logic [2:0] cmd; logic [2:0] lvl;
    logic [2:0] pulses; // {icw1, ocw2, poll}
  } vec_t;

  vec_t vt[12];

  initial begin
    model_reset();
    vt[0]  = '{1'b0, 8'h13, 1'b0, 5'h00, 3'b011, 8'h00, 5'h00, 8'h00, 3'd0, 3'd0, 3'b100};
    vt[1]  = '{1'b1, 8'h48, 1'b0, 5'h09, 3'b011, 8'h00, 5'h00, 8'h00, 3'd0, 3'd0, 3'b000};
    vt[2]  = '{1'b1, 8'h01, 1'b1, 5'h09, 3'b011, 8'h00, 5'h01, 8'h00, 3'd0, 3'd0, 3'b000};
    vt[3]  = '{1'b1, 8'hA5, 1'b1, 5'h09, 3'b011, 8'h00, 5'h01, 8'hA5, 3'd0, 3'd0, 3'b000};
    vt[4]  = '{1'b0, 8'h63, 1'b1, 5'h09, 3'b011, 8'h00, 5'h01, 8'hA5, 3'd3, 3'd3, 3'b010};
    vt[5]  = '{1'b0, 8'h0B, 1'b1, 5'h09, 3'b011, 8'h00, 5'h01, 8'hA5, 3'd3, 3'd3, 3'b000};
    vt[6]  = '{1'b0, 8'h0C, 1'b1, 5'h09, 3'b011, 8'h00, 5'h01, 8'hA5, 3'd3, 3'd3, 3'b001};
    vt[7]  = '{1'b0, 8'h11, 1'b0, 5'h09, 3'b001, 8'h00, 5'h00, 8'h00, 3'd3, 3'd3, 3'b100};
    vt[8]  = '{1'b1, 8'h20, 1'b0, 5'h04, 3'b001, 8'h00, 5'h00, 8'h00, 3'd3, 3'd3, 3'b000};
    vt[9]  = '{1'b0, 8'h05, 1'b0, 5'h04, 3'b001, 8'h00, 5'h00, 8'h00, 3'd3, 3'd3, 3'b000};
    vt[10] = '{1'b1, 8'h04, 1'b0, 5'h04, 3'b001, 8'h04, 5'h00, 8'h00, 3'd3, 3'd3, 3'b000};
    vt[11] = '{1'b1, 8'h03, 1'b1, 5'h04, 3'b001, 8'h04, 5'h03, 8'h00, 3'd3, 3'd3, 3'b000};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst init_done", init_done, 1'b0);
    chk("rst imr", imr, IMR_RST);
    chk("rst vector_base", vector_base, 5'h00);
    chk("rst read_data", read_data, 8'h00);
    chk("rst pulses", {icw1_pulse, ocw2_valid, poll_req}, 3'b000);
    reset = 1'b0;

    // Table: single init, OCWs, then cascade init
    for (int i = 0; i < 12; i++) begin
      model_write(vt[i].a, vt[i].d);
      do_write(vt[i].a, vt[i].d);
      chk($sformatf("vec%0d pulses", i), {s_icw1, s_ocw2, s_poll}, vt[i].pulses);
      chk($sformatf("vec%0d init_done", i), init_done, vt[i].done);
      chk($sformatf("vec%0d vector_base", i), vector_base, vt[i].vb);
      chk($sformatf("vec%0d ltim_sngl_ic4", i), {ltim, sngl, ic4}, vt[i].lsi);
      chk($sformatf("vec%0d cascade_cfg", i), cascade_cfg, vt[i].casc);
      chk($sformatf("vec%0d icw4_mode", i), icw4_mode, vt[i].i4);
      chk($sformatf("vec%0d imr", i), imr, vt[i].imr);
      chk($sformatf("vec%0d ocw2", i), {ocw2_cmd, ocw2_level}, {vt[i].cmd, vt[i].lvl});
      chk_pulses_clear($sformatf("vec%0d", i));
    end

    // Read-back selection
    irr = 8'h3C; isr = 8'h81;
    rd_chk("rd irr", 1'b0);
    chk("rd irr const", read_data, 8'h3C);
    wr_chk("ocw3 isr", 1'b0, 8'h0B);
    rd_chk("rd isr", 1'b0);
    chk("rd isr const", read_data, 8'h81);
    wr_chk("ocw1 a5", 1'b1, 8'hA5);
    rd_chk("rd imr", 1'b1);
    chk("rd imr const", read_data, 8'hA5);

    // rd_n and wr_n low together: no flags, no commit
    @(negedge clk); cs_n = 0; rd_n = 0; wr_n = 0; a0 = 0; data_in = 8'h13;
    @(negedge clk);
    chk("both_low flags", {rd_flag, wr_flag}, 2'b00);
    @(negedge clk); cs_n = 1; rd_n = 1; wr_n = 1;
    @(negedge clk);
    chk("both_low no_icw1", icw1_pulse, 1'b0);
    chk_model("both_low");

    // cs_n raised while wr_n still low: commit happens
    model_write(1'b1, 8'h5A);
    @(negedge clk); cs_n = 0; wr_n = 0; a0 = 1; data_in = 8'h5A;
    @(negedge clk);
    @(negedge clk); cs_n = 1;
    @(negedge clk);
    chk("cs_early imr", imr, 8'h5A);
    wr_n = 1;
    chk_model("cs_early");

    // Restart: second ICW1 in place of ICW3
    wr_chk("rs icw1", 1'b0, 8'h11);
    wr_chk("rs icw2", 1'b1, 8'h20);
    rd_chk("rs rd_notready", 1'b1);
    wr_chk("rs icw1b", 1'b0, 8'h11);
    chk("rs icw1b pulse", s_icw1, 1'b1);
    wr_chk("rs icw2b", 1'b1, 8'h28);
    chk("rs vb", vector_base, 5'h05);
    wr_chk("rs icw3", 1'b1, 8'h02);
    wr_chk("rs icw4", 1'b1, 8'h1F);

    // Reset asserted mid-write: pending ICW1 must be dropped
    @(negedge clk); cs_n = 0; wr_n = 0; a0 = 0; data_in = 8'h13;
    @(negedge clk);
    @(negedge clk); reset = 1; cs_n = 1; wr_n = 1;
    @(negedge clk);
    model_reset();
    chk("rstw imr", imr, IMR_RST);
    chk("rstw read_data", read_data, 8'h00);
    reset = 0;
    @(negedge clk);
    chk("rstw no_icw1", icw1_pulse, 1'b0);
    chk_model("rstw");

    // IDLE ignores everything except ICW1
    wr_chk("idle ocw1", 1'b1, 8'hFF);
    wr_chk("idle ocw2", 1'b0, 8'h20);

    // Randomized traffic against the model
    for (int n = 0; n < 250; n++) begin
      logic       a;
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        a = 0; d[4] = 1'b1;
      end else begin
        a = 1'($urandom);
        if (!a) d[4] = 1'b0;
      end
      wr_chk($sformatf("rnd%0d", n), a, d);
      if (n % 3 == 0) begin
        irr = 8'($urandom); isr = 8'($urandom);
        rd_chk($sformatf("rnd%0d", n), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
